// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 key matrix scanner.
// Frame bit index is {col_idx, row_idx}; a low bit means that key is closed.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef logic [1:0] col_state_t;
    localparam col_state_t COL1 = 2'd0;
    localparam col_state_t COL2 = 2'd1;
    localparam col_state_t COL3 = 2'd2;
    localparam col_state_t COL4 = 2'd3;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } frame_class_t;

    function automatic logic [4:0] count_low(input logic [NUM_ROWS*NUM_COLS-1:0] f);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < NUM_ROWS*NUM_COLS; i++) begin
            n = n + {4'd0, ~f[i]};
        end
        return n;
    endfunction

    // Only meaningful when exactly one bit is low; the index is the key code.
    function automatic key_code_t first_low(input logic [NUM_ROWS*NUM_COLS-1:0] f);
        key_code_t k;
        k = '0;
        for (int i = NUM_ROWS*NUM_COLS-1; i >= 0; i--) begin
            if (!f[i]) k = 4'(i);
        end
        return k;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key report bundle from the scanner to the consuming control logic.
interface keypad_scanner_if;
    import keypad_pkg::*;

    key_code_t key_code;
    logic      key_valid;
    logic      key_held;

    modport master (output key_code, output key_valid, output key_held);
    modport slave  (input  key_code, input  key_valid, input  key_held);
endinterface

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low matrix row inputs.
module row_sync (
    input  logic       clk,
    input  logic       rst_i,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);
    logic [3:0] meta_q, meta_d;
    logic [3:0] sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // Idle rows read high, so reset to "no key".
    always_ff @(posedge clk) begin
        if (rst_i) begin
            meta_q <= 4'b1111;
            sync_q <= 4'b1111;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: one-cold column drive, per-frame snapshot,
// ghost-rejecting classification and press/release debounce.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              ENA,
    input  logic [4:1]        row_ni,
    output logic [4:1]        col_no,
    keypad_scanner_if.master  key_bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]  rows_sync;
    col_state_t  col_q, col_d;
    logic [15:0] snap_q, snap_d;
    key_code_t   cand_q, cand_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;
    key_code_t   key_code_q, key_code_d;
    logic        key_valid_q, key_valid_d;
    logic        key_held_q, key_held_d;

    logic [4:0]   n_low;
    key_code_t    cand;
    frame_class_t fclass;

    row_sync u_row_sync (
        .clk   (clk),
        .rst_i (rst_i),
        .d_i   (row_ni),
        .q_o   (rows_sync)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COLS; gi++) begin : g_col_drive
            assign col_no[gi+1] = (col_q != col_state_t'(gi));
        end
    endgenerate

    always_comb begin
        col_d       = col_q;
        snap_d      = snap_q;
        cand_d      = cand_q;
        press_cnt_d = press_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        key_valid_d = 1'b0;

        if (ENA) begin
            snap_d[{col_q, 2'b00} +: 4] = rows_sync;
            col_d = col_q + 2'd1;
        end

        // snap_d already holds the column-4 slice being captured this tick.
        n_low  = count_low(snap_d);
        cand   = first_low(snap_d);
        fclass = (n_low == 5'd0) ? NONE : ((n_low == 5'd1) ? SINGLE : MULTI);

        if (ENA && (col_q == COL4)) begin
            case (fclass)
                SINGLE: begin
                    cand_d    = cand;
                    rel_cnt_d = '0;
                    if (cand == cand_q) begin
                        press_cnt_d = (press_cnt_q == CNT_MAX) ? CNT_MAX : press_cnt_q + CNT_ONE;
                    end else begin
                        press_cnt_d = CNT_ONE;
                    end
                    if ((press_cnt_d == CNT_MAX) && ((cand != key_code_q) || !key_held_q)) begin
                        key_code_d  = cand;
                        key_held_d  = 1'b1;
                        key_valid_d = 1'b1;
                    end
                end
                NONE: begin
                    press_cnt_d = '0;
                    rel_cnt_d   = (rel_cnt_q == CNT_MAX) ? CNT_MAX : rel_cnt_q + CNT_ONE;
                    if (rel_cnt_d == CNT_MAX) key_held_d = 1'b0;
                end
                default: begin
                    press_cnt_d = '0;
                    rel_cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            col_q       <= COL1;
            snap_q      <= '0;
            cand_q      <= '0;
            press_cnt_q <= '0;
            rel_cnt_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            snap_q      <= snap_d;
            cand_q      <= cand_d;
            press_cnt_q <= press_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign key_bus.key_code  = key_code_q;
    assign key_bus.key_valid = key_valid_q;
    assign key_bus.key_held  = key_held_q;
endmodule
